// File: rtl/fpu_simd_cmd_ctrl.sv
// +---------------------------------------------------------------------------+
// | fpu_simd_cmd_ctrl: software command sequencer for the shared FPU/SIMD     |
// | units. Optional macro: FPU_SIMD_CMD_TIMEOUT_EN.  Revision: 1.0            |
// +---------------------------------------------------------------------------+
`default_nettype none

module fpu_simd_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OPCODE_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_wr_en,
  input  logic                sw_rd_en,
  input  logic [31:0]         sw_address,
  input  logic [31:0]         sw_datain,
  output logic [31:0]         sw_dataout,
  output logic                sw_rd_valid,
  output logic                fpu_simd,
  output logic [OPCODE_W-1:0] unit_opcode,
  output logic                fpu_start,
  output logic                simd_start,
  input  logic                fpu_done,
  input  logic                simd_done,
  input  logic [31:0]         fpu_result,
  input  logic [31:0]         simd_result,
  output logic                busy
);

  localparam logic [31:0] ADDR_CMD    = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0110;
  localparam logic [31:0] ADDR_OUTPUT = 32'h0000_0130;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                cmd_unit;
  logic [OPCODE_W-1:0] cmd_opcode;
  logic                last_unit;
  logic                st_done;
  logic                st_err;
  logic [31:0]         out_reg;
  logic [31:0]         rd_data;

  logic cmd_wr_idle;
  logic go_accept;
  logic status_rd;
  logic sel_done;
  logic [31:0] sel_result;
  logic timeout_hit;
  logic issue_fire;
  logic capture;
  logic set_done;
  logic set_err;
  logic unused_bits;

  assign cmd_wr_idle = sw_wr_en && (sw_address == ADDR_CMD) && (state == S_IDLE);
  assign go_accept   = cmd_wr_idle && sw_datain[0];
  assign status_rd   = sw_rd_en && (sw_address == ADDR_STATUS);
  // fpu_simd cannot move while busy, so it is a safe selector for the done path.
  assign sel_done    = fpu_simd ? simd_done : fpu_done;
  assign sel_result  = fpu_simd ? simd_result : fpu_result;
  assign busy        = (state != S_IDLE);
  assign unit_opcode = cmd_opcode;
  assign unused_bits = ^{sw_datain[3:2], sw_datain[31:4+OPCODE_W]};

`ifdef FPU_SIMD_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A coincident done takes priority over the terminal count.
  assign timeout_hit = (state == S_WAIT) && !sel_done &&
                       (wait_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go_accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (sel_done)         state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue_fire = 1'b0;
    capture    = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_ISSUE: issue_fire = 1'b1;
      S_WAIT: begin
        capture = sel_done;
        set_err = timeout_hit;
      end
      S_DONE:  set_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    case (sw_address)
      ADDR_CMD: begin
        rd_data[1]             = cmd_unit;
        rd_data[4 +: OPCODE_W] = cmd_opcode;
      end
      ADDR_STATUS: rd_data = {28'h0, last_unit, st_err, st_done, busy};
      ADDR_OUTPUT: rd_data = out_reg;
      default:     rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_unit    <= 1'b0;
      cmd_opcode  <= '0;
      last_unit   <= 1'b0;
      fpu_simd    <= 1'b0;
      st_done     <= 1'b0;
      st_err      <= 1'b0;
      out_reg     <= 32'h0;
      fpu_start   <= 1'b0;
      simd_start  <= 1'b0;
      sw_dataout  <= 32'h0;
      sw_rd_valid <= 1'b0;
    end else begin
      if (cmd_wr_idle) begin
        cmd_unit   <= sw_datain[1];
        cmd_opcode <= sw_datain[4 +: OPCODE_W];
      end
      if (go_accept) begin
        fpu_simd  <= sw_datain[1];
        last_unit <= sw_datain[1];
      end
      // Registered launch lands one cycle after ISSUE, i.e. the first WAIT cycle.
      fpu_start  <= issue_fire && !fpu_simd;
      simd_start <= issue_fire && fpu_simd;
      if (capture) out_reg <= sel_result;

      if (set_done)       st_done <= 1'b1;
      else if (status_rd) st_done <= 1'b0;
      if (set_err)        st_err  <= 1'b1;
      else if (status_rd) st_err  <= 1'b0;

      sw_rd_valid <= sw_rd_en;
      if (sw_rd_en) sw_dataout <= rd_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_simd_cmd_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_fpu_simd_cmd_ctrl: bench for fpu_simd_cmd_ctrl.  Revision: 1.0         |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_fpu_simd_cmd_ctrl;

  localparam logic [31:0] A_CMD = 32'h0, A_ST = 32'h110, A_OUT = 32'h130;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_wr_en, sw_rd_en;
  logic [31:0] sw_address, sw_datain, sw_dataout;
  logic        sw_rd_valid, fpu_simd, fpu_start, simd_start;
  logic [3:0]  unit_opcode;
  logic        fpu_done, simd_done, busy;
  logic [31:0] fpu_result, simd_result;

  always #5 clk = ~clk;

  fpu_simd_cmd_ctrl #(.TIMEOUT_CYCLES(16), .OPCODE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .sw_wr_en(sw_wr_en), .sw_rd_en(sw_rd_en),
    .sw_address(sw_address), .sw_datain(sw_datain),
    .sw_dataout(sw_dataout), .sw_rd_valid(sw_rd_valid),
    .fpu_simd(fpu_simd), .unit_opcode(unit_opcode),
    .fpu_start(fpu_start), .simd_start(simd_start),
    .fpu_done(fpu_done), .simd_done(simd_done),
    .fpu_result(fpu_result), .simd_result(simd_result),
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_fpu_start = 0;
  int n_simd_start = 0;
  logic [31:0] exp_q[$];
  int          tag_q[$];
  int          next_tag = 0;
  logic [31:0] mon_exp;
  int          mon_tag;

  typedef struct {
    logic        do_wr;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Read scoreboard: every read pushes its expected data; rd_valid pops it.
  always @(negedge clk) begin
    if (fpu_start)  n_fpu_start++;
    if (simd_start) n_simd_start++;
    if (sw_rd_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_valid_unexpected: got data %h, expected no read", sw_dataout);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (sw_dataout !== mon_exp) begin
          n_err++;
          $display("FAIL read#%0d: got %h, expected %h", mon_tag, sw_dataout, mon_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sw_write(input logic [31:0] a, input logic [31:0] d);
    sw_wr_en = 1'b1; sw_address = a; sw_datain = d;
    cyc();
    sw_wr_en = 1'b0;
  endtask

  task automatic sw_read(input logic [31:0] a, input logic [31:0] e);
    sw_rd_en = 1'b1; sw_address = a;
    exp_q.push_back(e); tag_q.push_back(next_tag); next_tag++;
    cyc();
    sw_rd_en = 1'b0;
  endtask

  task automatic sw_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    sw_wr_en = 1'b1; sw_rd_en = 1'b1; sw_address = a; sw_datain = d;
    exp_q.push_back(e); tag_q.push_back(next_tag); next_tag++;
    cyc();
    sw_wr_en = 1'b0; sw_rd_en = 1'b0;
  endtask

  task automatic pulse(input logic unit, input logic [31:0] data);
    if (unit) begin simd_done = 1'b1; simd_result = data; end
    else      begin fpu_done  = 1'b1; fpu_result  = data; end
    cyc();
    fpu_done = 1'b0; simd_done = 1'b0; fpu_result = 32'h0; simd_result = 32'h0;
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0,   32'h0,         A_CMD,        32'h0};
    vecs[1] = '{1'b0, 32'h0,   32'h0,         A_ST,         32'h0};
    vecs[2] = '{1'b0, 32'h0,   32'h0,         A_OUT,        32'h0};
    vecs[3] = '{1'b0, 32'h0,   32'h0,         32'h0000_0004, 32'h0};
    vecs[4] = '{1'b1, A_CMD,   32'h0000_00A0, A_CMD,        32'h0000_00A0};
    vecs[5] = '{1'b1, A_OUT,   32'h0000_0055, A_OUT,        32'h0};
    vecs[6] = '{1'b1, A_CMD,   32'hFFFF_FFFE, A_CMD,        32'h0000_00F2};
    vecs[7] = '{1'b1, 32'h4,   32'hFFFF_FFFF, A_CMD,        32'h0000_00F2};

    rst_n = 1'b0; sw_wr_en = 1'b0; sw_rd_en = 1'b0; sw_address = 32'h0; sw_datain = 32'h0;
    fpu_done = 1'b0; simd_done = 1'b0; fpu_result = 32'h0; simd_result = 32'h0;
    repeat (3) cyc();
    check("reset_outputs",
          {sw_dataout, 27'h0, sw_rd_valid, fpu_simd, fpu_start, simd_start, busy}, 64'h0);
    check("reset_opcode", {28'h0, unit_opcode}, 32'h0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) sw_write(vecs[i].wr_addr, vecs[i].wdata);
      sw_read(vecs[i].rd_addr, vecs[i].exp);
    end
    check("idle_write_no_sel", {31'h0, fpu_simd}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);

    // FPU operation: go at N, start at N+2, done five cycles after start.
    sw_write(A_CMD, 32'h0000_0031);
    check("fpu_issue_busy", {31'h0, busy}, 32'h1);
    check("fpu_issue_nostart", {30'h0, fpu_start, simd_start}, 32'h0);
    check("fpu_sel", {31'h0, fpu_simd}, 32'h0);
    check("fpu_opcode", {28'h0, unit_opcode}, 32'h3);
    cyc();
    check("fpu_start_n2", {30'h0, fpu_start, simd_start}, 32'h2);
    sw_read(A_ST, 32'h1);
    check("fpu_start_pulse", {30'h0, fpu_start, simd_start}, 32'h0);
    repeat (4) cyc();
    pulse(1'b0, 32'h3F80_0000);
    check("fpu_done_busy", {31'h0, busy}, 32'h1);
    sw_read(A_ST, 32'h1);
    check("fpu_idle", {31'h0, busy}, 32'h0);
    sw_read(A_ST, 32'h2);
    sw_read(A_ST, 32'h0);
    sw_read(A_OUT, 32'h3F80_0000);

    // SIMD operation with an ignored CMD write and a wrong-unit done.
    sw_write(A_CMD, 32'h0000_0053);
    check("simd_sel", {31'h0, fpu_simd}, 32'h1);
    cyc();
    check("simd_start_n2", {30'h0, fpu_start, simd_start}, 32'h1);
    sw_write(A_CMD, 32'h0000_0001);
    check("busy_write_sel", {31'h0, fpu_simd}, 32'h1);
    sw_read(A_CMD, 32'h0000_0052);
    pulse(1'b0, 32'hDEAD_BEEF);
    check("simd_wrong_done", {31'h0, busy}, 32'h1);
    repeat (3) cyc();
    check("simd_no_restart", {30'h0, fpu_start, simd_start}, 32'h0);
    pulse(1'b1, 32'hCAFE_0001);
    sw_read(A_ST, 32'h9);
    sw_read(A_ST, 32'hA);
    sw_read(A_ST, 32'h8);
    sw_read(A_OUT, 32'hCAFE_0001);
    check("simd_sel_held", {31'h0, fpu_simd}, 32'h1);

    // FPU selected, SIMD done ignored, FPU done latched.
    sw_write(A_CMD, 32'h0000_0011);
    repeat (3) cyc();
    pulse(1'b1, 32'hDEAD_BEEF);
    check("wrong_unit_wait", {31'h0, busy}, 32'h1);
    sw_read(A_OUT, 32'hCAFE_0001);
    pulse(1'b0, 32'h1234_5678);
    cyc();
    sw_read(A_ST, 32'h2);
    sw_read(A_ST, 32'h0);
    sw_read(A_OUT, 32'h1234_5678);

    // Done pulses in IDLE are ignored.
    pulse(1'b0, 32'h0000_0099);
    pulse(1'b1, 32'h0000_0098);
    sw_read(A_OUT, 32'h1234_5678);
    sw_read(A_ST, 32'h0);

    // Simultaneous read and write returns the pre-write value.
    sw_rw(A_CMD, 32'h0000_0070, 32'h0000_0010);
    sw_read(A_CMD, 32'h0000_0070);

`ifdef FPU_SIMD_CMD_TIMEOUT_EN
    begin
      int k;
      sw_write(A_CMD, 32'h0000_0021);
      cyc();
      k = 0;
      while (busy && k < 40) begin cyc(); k++; end
      check("timeout_latency_ok", {31'h0, (k >= 15 && k <= 20)}, 32'h1);
      sw_read(A_ST, 32'h4);
      sw_read(A_OUT, 32'h1234_5678);
      sw_read(A_ST, 32'h0);
    end
`else
    sw_write(A_CMD, 32'h0000_0021);
    repeat (40) cyc();
    check("wait_persists", {31'h0, busy}, 32'h1);
    sw_read(A_ST, 32'h1);
    pulse(1'b0, 32'h0BAD_F00D);
    cyc();
    sw_read(A_ST, 32'h2);
    sw_read(A_OUT, 32'h0BAD_F00D);
`endif

    // Reset mid-operation, then a stale done from the aborted unit.
    sw_write(A_CMD, 32'h0000_0043);
    cyc();
    cyc();
    check("abort_in_wait", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("abort_outputs", {26'h0, unit_opcode, fpu_simd, busy}, 32'h0);
    pulse(1'b1, 32'h0000_0077);
    check("abort_stale_done", {31'h0, busy}, 32'h0);
    sw_read(A_CMD, 32'h0);
    sw_read(A_ST, 32'h0);
    sw_read(A_OUT, 32'h0);

    repeat (3) cyc();
    check("fpu_start_count", n_fpu_start, 3);
    check("simd_start_count", n_simd_start, 2);
    check("reads_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_simd_cmd_ctrl.md
Name: fpu_simd_cmd_ctrl

Overview:
- Software-facing command sequencer for the shared FPU and SIMD execution units.
- Decodes software register writes and launches one operation at a time on the selected unit.
- Waits for that unit's done handshake, then latches the result and updates status.
- Drives the fpu_simd select and the software read-data path for the command, status and output registers.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before an operation is aborted with an error (only used with the optional feature).
- OPCODE_W, 4: width of the opcode field forwarded to both units.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- sw_wr_en  input  1  software write strobe, single cycle.
- sw_rd_en  input  1  software read strobe, single cycle.
- sw_address  input  32  software register address.
- sw_datain  input  32  software write data.
- sw_dataout  output  32  software read data, registered.
- sw_rd_valid  output  1  one-cycle pulse qualifying sw_dataout.
- fpu_simd  output  1  selected unit: 0 = FPU, 1 = SIMD.
- unit_opcode  output  OPCODE_W  opcode presented to both units.
- fpu_start  output  1  one-cycle launch pulse to the FPU.
- simd_start  output  1  one-cycle launch pulse to the SIMD unit.
- fpu_done  input  1  FPU completion pulse.
- simd_done  input  1  SIMD completion pulse.
- fpu_result  input  32  FPU result, valid while fpu_done is high.
- simd_result  input  32  SIMD result, valid while simd_done is high.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Register map:
  - 0x0000_0000 CMD (R/W): bit0 go (write-only, reads 0); bit1 unit; bits[4+OPCODE_W-1:4] opcode.
  - 0x0000_0110 STATUS (RO): bit0 busy; bit1 done (sticky); bit2 err (sticky); bit3 unit of last operation.
  - 0x0000_0130 OUTPUT (RO): last latched result.
  - Any other address reads 0x0000_0000; writes to it are ignored.
- Reset: state IDLE. All outputs low or zero, including sw_dataout, sw_rd_valid, fpu_simd, unit_opcode, both start pulses and busy. CMD, STATUS and OUTPUT clear to 0.
- Reads: sw_dataout and sw_rd_valid update one cycle after sw_rd_en. sw_dataout holds its value until the next read. Reading STATUS clears done and err in the same cycle the read data is captured.
- FSM states:
  - IDLE: a CMD write with go=1 latches unit and opcode, drives fpu_simd=unit, then moves to ISSUE.
  - ISSUE (1 cycle): asserts exactly one of fpu_start or simd_start, according to unit. Moves to WAIT.
  - WAIT: on the done input of the selected unit, latches that unit's result into OUTPUT and moves to DONE. The done input of the non-selected unit is ignored.
  - DONE (1 cycle): sets STATUS.done=1, then returns to IDLE.
- Latency: go write at cycle N gives start high at N+2. A done pulse at cycle M makes OUTPUT valid at M+1 and STATUS.done=1 at M+2.
- CMD writes while busy: ignored completely, including the unit and opcode fields. CMD reads return the latched unit and opcode.
- fpu_simd is held stable from IDLE exit until the next accepted go. It is not changed by ignored writes.
- If a STATUS read clear and a done set land in the same cycle, the set wins.
- Simultaneous read and write in the same cycle: both are serviced; the read returns the pre-write value.
- A done pulse arriving in the same cycle as its start is not possible by contract. A done pulse in IDLE, ISSUE or DONE is ignored.
- Reset asserted mid-operation: return to IDLE next cycle and clear everything. A later done pulse from the aborted unit is ignored.

Optional Feature:
- Macro: FPU_SIMD_CMD_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without a done, the block sets STATUS.err=1, leaves OUTPUT unchanged and goes to IDLE without setting done.
  - If done and the terminal count coincide, done wins and err stays 0.
- Undefined: no counter; WAIT persists until done or reset, and err always reads 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0; reads of CMD, STATUS and OUTPUT return 0x0.
- FPU op: write CMD=0x0000_0031 (go, FPU, opcode 3); FPU returns done with 0x3F80_0000 five cycles after start -> fpu_start is one pulse at N+2 and simd_start stays 0; STATUS reads 0x1 while busy then 0x2 after completion; OUTPUT reads 0x3F80_0000.
- SIMD op then busy write: write CMD=0x0000_0053; while in WAIT write CMD=0x0000_0001 -> only simd_start pulses; fpu_simd stays 1 throughout; CMD read returns 0x0000_0052; STATUS reads 0xA after completion.
- Sticky clear: complete an op, read STATUS twice -> first read 0x2 (FPU) or 0xA (SIMD), second read 0x0 or 0x8 respectively.
- Wrong-unit done: select FPU, pulse simd_done with 0xDEAD_BEEF -> remains in WAIT and OUTPUT unchanged; a later fpu_done with 0x1234_5678 is latched.
- Timeout (macro defined, TIMEOUT_CYCLES=16): issue FPU op and never assert done -> busy drops about 18 cycles after start; STATUS reads 0x4; OUTPUT unchanged.
